// File: rtl/sd_pkg.sv
// Shared constants for the SD-bus one-time-pad path: RAM geometry, keystream width
// and the otp_xor state encoding.
package sd_pkg;

   localparam int ADDR_W  = 10;
   localparam int GAMMA_W = 64;
   localparam int NIBBLES = GAMMA_W / 4;
   localparam int SEL_W   = $clog2(NIBBLES);

   localparam logic [2:0] OTP_IDLE  = 3'd0;
   localparam logic [2:0] OTP_REQ   = 3'd1;
   localparam logic [2:0] OTP_XOR   = 3'd2;
   localparam logic [2:0] OTP_DRAIN = 3'd3;
   localparam logic [2:0] OTP_DONE  = 3'd4;

   // Nibble k of a keystream word lives at bits [4k+3:4k].
   function automatic logic [3:0] gamma_nibble(input logic [GAMMA_W-1:0] word,
                                               input logic [SEL_W-1:0]   k);
      return word[{k, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/otp_gamma_buf.sv
// Holds the current keystream word and presents the selected nibble combinationally.
module otp_gamma_buf
   import sd_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [GAMMA_W-1:0] word,
   input  logic [SEL_W-1:0]   sel,
   output logic [3:0]         nibble
);

   logic [GAMMA_W-1:0] word_r;

   // Capture a keystream word on the accepting edge of the request handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_r <= {GAMMA_W{1'b0}};
      end else if (load) begin
         word_r <= word;
      end else begin
         word_r <= word_r;
      end
   end

   assign nibble = gamma_nibble(word_r, sel);

endmodule

// File: rtl/otp_xor.sv
// One-time-pad stage: reads a block of nibbles from the received RAM, XORs each with
// keystream nibbles from the gamma generator and writes the result to the processed RAM.
module otp_xor
   import sd_pkg::*;
(
   input  logic               iclk,
   input  logic               irst,
   input  logic               igen,
   input  logic               inew,
   output logic               oready,
   output logic [ADDR_W-1:0]  oraddr,
   input  logic [3:0]         irdata,
   output logic [ADDR_W-1:0]  owaddr,
   output logic [3:0]         owdata,
   output logic               owe,
   output logic               onew_gamma,
   output logic               oreq_gamma,
   input  logic               igamma_valid,
   input  logic [GAMMA_W-1:0] igamma
);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [SEL_W-1:0]  sel_d;
   logic [3:0]        gamma_nib;
   logic              issue;
   logic              accept;
   logic              word_last;
   logic              block_last;

   assign issue      = (state == OTP_XOR);
   // Hold the request back while the generator is being reinitialised so the
   // new-pad pulse is always seen before the first keystream request.
   assign oreq_gamma = (state == OTP_REQ) && !onew_gamma;
   assign accept     = oreq_gamma && igamma_valid;
   assign word_last  = (addr[SEL_W-1:0] == SEL_W'(NIBBLES - 1));
   assign block_last = (addr == {ADDR_W{1'b1}});
   assign oraddr     = addr;

   // Next-state decode for the block sequencer.
   always_comb begin
      state_nxt = state;
      case (state)
         OTP_IDLE: begin
            if (igen) state_nxt = OTP_REQ;
            else      state_nxt = OTP_IDLE;
         end
         OTP_REQ: begin
            if (accept) state_nxt = OTP_XOR;
            else        state_nxt = OTP_REQ;
         end
         OTP_XOR: begin
            if (word_last && block_last) state_nxt = OTP_DRAIN;
            else if (word_last)          state_nxt = OTP_REQ;
            else                         state_nxt = OTP_XOR;
         end
         OTP_DRAIN: state_nxt = OTP_DONE;
         OTP_DONE:  state_nxt = OTP_IDLE;
         default:   state_nxt = OTP_IDLE;
      endcase
   end

   // Sequencer state, address counter and the one-stage read/write pipeline.
   always_ff @(posedge iclk) begin
      if (irst) begin
         state      <= OTP_IDLE;
         addr       <= {ADDR_W{1'b0}};
         sel_d      <= {SEL_W{1'b0}};
         owaddr     <= {ADDR_W{1'b0}};
         owe        <= 1'b0;
         oready     <= 1'b0;
         onew_gamma <= 1'b0;
      end else begin
         state      <= state_nxt;
         sel_d      <= addr[SEL_W-1:0];
         owaddr     <= addr;
         owe        <= issue;
         oready     <= (state == OTP_DONE);
         onew_gamma <= (state == OTP_IDLE) && inew;
         if ((state == OTP_IDLE) && inew) begin
            addr <= {ADDR_W{1'b0}};
         end else if (state == OTP_DONE) begin
            addr <= {ADDR_W{1'b0}};
         end else if (issue) begin
            addr <= addr + ADDR_W'(1);
         end else begin
            addr <= addr;
         end
      end
   end

   otp_gamma_buf u_gamma_buf (
      .clk    (iclk),
      .rst    (irst),
      .load   (accept),
      .word   (igamma),
      .sel    (sel_d),
      .nibble (gamma_nib)
   );

   // RAM data arrives one cycle after its address, aligned with the delayed nibble select.
   assign owdata = owe ? (irdata ^ gamma_nib) : 4'h0;

endmodule

// File: tb/tb_otp_xor.sv
// Scoreboard bench for otp_xor: RAM and gamma-generator models, expected writes queued
// per block, and a negedge monitor that pops and compares on every owe.
`timescale 1ns/1ps
module tb_otp_xor;
   import sd_pkg::*;

   localparam int BLK = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        data;
   } exp_t;

   logic               iclk = 1'b0;
   logic               irst = 1'b1;
   logic               igen = 1'b0;
   logic               inew = 1'b0;
   logic               oready;
   logic [ADDR_W-1:0]  oraddr;
   logic [3:0]         irdata;
   logic [ADDR_W-1:0]  owaddr;
   logic [3:0]         owdata;
   logic               owe;
   logic               onew_gamma;
   logic               oreq_gamma;
   logic               igamma_valid;
   logic [GAMMA_W-1:0] igamma;

   logic [3:0]         ram   [0:BLK-1];
   logic [3:0]         proc  [0:BLK-1];
   logic [GAMMA_W-1:0] gwords[0:127];
   logic [6:0]         gidx = 7'd0;
   int                 wcnt = 0;
   int                 stall_n = 0;
   int                 cyc = 0;
   exp_t               sbq[$];

   int n_cmp = 0;
   int n_bad = 0;
   int owe_cnt = 0, ready_cnt = 0, new_cnt = 0, req_cnt = 0;
   int stall_viol = 0, drop_viol = 0, new_at_req = -1, first_waddr = -1;
   logic oreq_prev = 1'b0, acc_prev = 1'b0;

   otp_xor dut (
      .iclk         (iclk),
      .irst         (irst),
      .igen         (igen),
      .inew         (inew),
      .oready       (oready),
      .oraddr       (oraddr),
      .irdata       (irdata),
      .owaddr       (owaddr),
      .owdata       (owdata),
      .owe          (owe),
      .onew_gamma   (onew_gamma),
      .oreq_gamma   (oreq_gamma),
      .igamma_valid (igamma_valid),
      .igamma       (igamma)
   );

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   // Received RAM (one-cycle read latency) and processed RAM.
   always @(posedge iclk) begin
      irdata <= ram[oraddr];
      if (owe) proc[owaddr] <= owdata;
   end

   // Gamma generator: stall_n cycles of no-valid per request, restart on onew_gamma.
   always @(posedge iclk) begin
      if (onew_gamma)                      gidx <= 7'd0;
      else if (oreq_gamma && igamma_valid) gidx <= gidx + 7'd1;
      if (oreq_gamma && !igamma_valid) wcnt <= wcnt + 1;
      else                             wcnt <= 0;
   end
   assign igamma_valid = (wcnt >= stall_n);
   assign igamma       = gwords[gidx];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every write, track handshake statistics.
   always @(negedge iclk) begin
      exp_t e;
      if (owe) begin
         owe_cnt++;
         if (first_waddr < 0) first_waddr = int'(owaddr);
         if (oreq_gamma && oreq_prev && !acc_prev) stall_viol++;
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write", owaddr, owdata);
         end else begin
            e = sbq.pop_front();
            if (owaddr !== e.addr || owdata !== e.data) begin
               n_bad++;
               $display("FAIL sb_write: got addr %0h data %0h expected addr %0h data %0h",
                        owaddr, owdata, e.addr, e.data);
            end
         end
      end
      if (oready) ready_cnt++;
      if (onew_gamma) new_cnt++;
      if (oreq_gamma && !oreq_prev) begin
         if (req_cnt == 0) new_at_req = new_cnt;
         req_cnt++;
      end
      if (oreq_prev && !acc_prev && !oreq_gamma) drop_viol++;
      oreq_prev = oreq_gamma;
      acc_prev  = oreq_gamma && igamma_valid;
   end

   task automatic clr_stats();
      owe_cnt = 0; ready_cnt = 0; new_cnt = 0; req_cnt = 0;
      stall_viol = 0; drop_viol = 0; new_at_req = -1; first_waddr = -1;
   endtask

   task automatic push_block(input int base);
      logic [GAMMA_W-1:0] w;
      exp_t e;
      for (int a = 0; a < BLK; a++) begin
         w      = gwords[(base + a / 16) % 128];
         e.addr = ADDR_W'(a);
         e.data = ram[a] ^ w[(a % 16) * 4 +: 4];
         sbq.push_back(e);
      end
   endtask

   task automatic pulse_gen(output int at_cyc);
      @(negedge iclk);
      igen   = 1'b1;
      at_cyc = cyc;
      @(negedge iclk);
      igen   = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int budget, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge iclk);
         if (oready) begin
            at_cyc = cyc;
            break;
         end
      end
      if (at_cyc < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no oready within %0d cycles expected oready", name, budget);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_oready"}, oready, 0);
      chk({tag, "_owe"}, owe, 0);
      chk({tag, "_oreq"}, oreq_gamma, 0);
      chk({tag, "_onew"}, onew_gamma, 0);
      chk({tag, "_oraddr"}, oraddr, 0);
      chk({tag, "_owaddr"}, owaddr, 0);
      chk({tag, "_owdata"}, owdata, 0);
   endtask

   initial begin
      int c0, rdy;
      for (int a = 0; a < BLK; a++) ram[a] = 4'hA;
      for (int i = 0; i < 128; i++) gwords[i] = 64'h0123456789ABCDEF;

      // Reset state
      repeat (3) @(negedge iclk);
      chk_outputs_zero("reset");
      irst = 1'b0;
      repeat (2) @(negedge iclk);

      // Test 1: constant data, zero-wait gamma, latency and processed RAM pattern
      clr_stats();
      push_block(int'(gidx));
      pulse_gen(c0);
      wait_ready("t1_ready", 1200, rdy);
      chk("t1_latency", rdy - c0, 1091);
      @(negedge iclk);
      chk("t1_ready_width", oready, 0);
      repeat (3) @(negedge iclk);
      chk("t1_proc0", proc[0], 4'h5);
      chk("t1_proc1", proc[1], 4'h4);
      chk("t1_proc15", proc[15], 4'hA);
      chk("t1_proc16", proc[16], 4'h5);
      chk("t1_proc1023", proc[1023], 4'hA);
      chk("t1_owe_cnt", owe_cnt, 1024);
      chk("t1_ready_cnt", ready_cnt, 1);
      chk("t1_req_cnt", req_cnt, 64);

      // Test 2: five-cycle stall on every request
      stall_n = 5;
      clr_stats();
      push_block(int'(gidx));
      pulse_gen(c0);
      wait_ready("t2_ready", 2000, rdy);
      repeat (3) @(negedge iclk);
      chk("t2_owe_cnt", owe_cnt, 1024);
      chk("t2_req_cnt", req_cnt, 64);
      chk("t2_owe_during_stall", stall_viol, 0);
      chk("t2_req_dropped", drop_viol, 0);
      chk("t2_proc1", proc[1], 4'h4);
      stall_n = 0;

      // Test 3: inew and igen together
      clr_stats();
      push_block(0);
      @(negedge iclk);
      inew = 1'b1;
      igen = 1'b1;
      @(negedge iclk);
      inew = 1'b0;
      igen = 1'b0;
      wait_ready("t3_ready", 1200, rdy);
      repeat (3) @(negedge iclk);
      chk("t3_new_cnt", new_cnt, 1);
      chk("t3_new_before_req", new_at_req, 1);
      chk("t3_first_waddr", first_waddr, 0);

      // Test 4: igen while busy is ignored
      clr_stats();
      push_block(int'(gidx));
      pulse_gen(c0);
      while (cyc - c0 < 10) @(negedge iclk);
      pulse_gen(rdy);
      while (cyc - c0 < 200) @(negedge iclk);
      pulse_gen(rdy);
      while (cyc - c0 < 500) @(negedge iclk);
      pulse_gen(rdy);
      wait_ready("t4_ready", 1200, rdy);
      repeat (30) @(negedge iclk);
      chk("t4_req_cnt", req_cnt, 64);
      chk("t4_owe_cnt", owe_cnt, 1024);
      chk("t4_ready_cnt", ready_cnt, 1);
      chk("t4_sb_left", sbq.size(), 0);

      // Test 5: reset mid-block, then a clean restart
      clr_stats();
      push_block(int'(gidx));
      pulse_gen(c0);
      while (cyc - c0 < 300) @(negedge iclk);
      irst = 1'b1;
      @(negedge iclk);
      chk_outputs_zero("t5_abort");
      irst = 1'b0;
      sbq.delete();
      repeat (2) @(negedge iclk);
      clr_stats();
      push_block(int'(gidx));
      pulse_gen(c0);
      wait_ready("t5_ready", 1200, rdy);
      repeat (3) @(negedge iclk);
      chk("t5_first_waddr", first_waddr, 0);
      chk("t5_owe_cnt", owe_cnt, 1024);
      chk("t5_ready_cnt", ready_cnt, 1);

      // Test 6: random data over two consecutive blocks of one pad
      for (int a = 0; a < BLK; a++) ram[a] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 128; i++) gwords[i] = {$urandom, $urandom};
      clr_stats();
      @(negedge iclk);
      inew = 1'b1;
      @(negedge iclk);
      inew = 1'b0;
      repeat (3) @(negedge iclk);
      push_block(0);
      pulse_gen(c0);
      wait_ready("t6_ready_a", 1200, rdy);
      repeat (3) @(negedge iclk);
      push_block(64);
      pulse_gen(c0);
      wait_ready("t6_ready_b", 1200, rdy);
      repeat (3) @(negedge iclk);
      chk("t6_owe_cnt", owe_cnt, 2048);
      chk("t6_ready_cnt", ready_cnt, 2);
      chk("t6_new_cnt", new_cnt, 1);
      chk("t6_req_cnt", req_cnt, 128);
      chk("t6_sb_left", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
